// File: rtl/hex_msg_sched.sv
// Round-robin scheduler for read/write report messages shown on a six-digit hex display.
// Each accepted message is held on screen for HOLD_CYCLES before the next one is taken.
module hex_msg_sched #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_valid,
    output logic       rd_ready,
    input  logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clear,
    output logic [4:0] hex5,
    output logic [4:0] hex4,
    output logic [4:0] hex3,
    output logic [4:0] hex2,
    output logic [4:0] hex1,
    output logic [4:0] hex0,
    output logic       busy,
    output logic       last_src
);

    localparam logic [4:0] CodeR     = 5'd16;
    localparam logic [4:0] CodeD     = 5'd17;
    localparam logic [4:0] CodeT     = 5'd18;
    localparam logic [4:0] CodeBlank = 5'd31;

    localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0][4:0]  disp_q, disp_d;
    logic             last_src_q, last_src_d;

    logic             can_accept;
    logic [7:0]       sel_addr;
    logic [7:0]       sel_data;

    // Ties go to the source that did not win last time.
    always_comb begin
        can_accept = (state_q == StIdle) && !clear;
        rd_ready   = can_accept && rd_valid && (!wr_valid || last_src_q);
        wr_ready   = can_accept && wr_valid && (!rd_valid || !last_src_q);
        sel_addr   = wr_ready ? wr_addr : rd_addr;
        sel_data   = wr_ready ? wr_data : rd_data;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        last_src_d = last_src_q;

        if (clear) begin
            state_d = StIdle;
            cnt_d   = '0;
            disp_d  = {6{CodeBlank}};
        end else begin
            case (state_q)
                StIdle: begin
                    if (rd_ready || wr_ready) begin
                        state_d    = StHold;
                        cnt_d      = HoldLoad;
                        last_src_d = wr_ready;
                        disp_d[5]  = wr_ready ? CodeD : CodeR;
                        disp_d[4]  = wr_ready ? CodeT : CodeD;
                        disp_d[3]  = {1'b0, sel_addr[7:4]};
                        disp_d[2]  = {1'b0, sel_addr[3:0]};
                        disp_d[1]  = {1'b0, sel_data[7:4]};
                        disp_d[0]  = {1'b0, sel_data[3:0]};
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            disp_q     <= {6{CodeBlank}};
            last_src_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            last_src_q <= last_src_d;
        end
    end

    assign hex5     = disp_q[5];
    assign hex4     = disp_q[4];
    assign hex3     = disp_q[3];
    assign hex2     = disp_q[2];
    assign hex1     = disp_q[1];
    assign hex0     = disp_q[0];
    assign busy     = (state_q == StHold);
    assign last_src = last_src_q;

endmodule

// File: tb/tb_hex_msg_sched.sv
// Self-checking bench for hex_msg_sched: one instance with a 4-cycle hold, one with a 1-cycle hold.
module tb_hex_msg_sched;

    logic       clk = 1'b0;
    logic       rst, rd_valid, wr_valid, clear;
    logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
    logic       rd_ready, wr_ready, busy, last_src;
    logic [4:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic [29:0] disp;

    logic       b_rst, b_rd_valid, b_wr_valid, b_clear;
    logic [7:0] b_rd_addr, b_rd_data, b_wr_addr, b_wr_data;
    logic       b_rd_ready, b_wr_ready, b_busy, b_last_src;
    logic [4:0] b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0;
    logic [29:0] b_disp;

    localparam logic [29:0] Blank = {6{5'd31}};

    int tests = 0;
    int fails = 0;
    logic [29:0] exp_q[$];

    typedef struct {
        logic        src;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [29:0] disp;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    hex_msg_sched #(.HOLD_CYCLES(4), .CNT_W(26)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear(clear),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .busy(busy), .last_src(last_src)
    );

    hex_msg_sched #(.HOLD_CYCLES(1), .CNT_W(26)) dut_b (
        .clk(clk), .rst(b_rst),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .clear(b_clear),
        .hex5(b_hex5), .hex4(b_hex4), .hex3(b_hex3), .hex2(b_hex2), .hex1(b_hex1), .hex0(b_hex0),
        .busy(b_busy), .last_src(b_last_src)
    );

    assign disp   = {hex5, hex4, hex3, hex2, hex1, hex0};
    assign b_disp = {b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0};

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_disp(input string name, input logic [29:0] act, input logic [29:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input string name);
        logic [29:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty at %0t", name, $time);
        end else begin
            e = exp_q.pop_front();
            check_disp(name, disp, e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy got 1 expected 0 after %0d cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0; clear = 1'b0;
        rd_addr = '0; rd_data = '0; wr_addr = '0; wr_data = '0;
        b_rst = 1'b1; b_rd_valid = 1'b0; b_wr_valid = 1'b0; b_clear = 1'b0;
        b_rd_addr = 8'h7E; b_rd_data = 8'h81; b_wr_addr = '0; b_wr_data = '0;

        vecs[0] = '{1'b0, 8'h3C, 8'hA5, {5'd16, 5'd17, 5'd3, 5'd12, 5'd10, 5'd5}};
        vecs[1] = '{1'b1, 8'h12, 8'h9F, {5'd17, 5'd18, 5'd1, 5'd2, 5'd9, 5'd15}};
        vecs[2] = '{1'b0, 8'h00, 8'hFF, {5'd16, 5'd17, 5'd0, 5'd0, 5'd15, 5'd15}};
        vecs[3] = '{1'b1, 8'hE7, 8'h4B, {5'd17, 5'd18, 5'd14, 5'd7, 5'd4, 5'd11}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0; b_rst = 1'b0;
        #1;
        check_disp("reset_disp", disp, Blank);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_last_src", last_src, 1'b1);

        // Single messages from the table; payload is scrambled right after accept.
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            if (vecs[i].src) begin
                wr_valid = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
            end else begin
                rd_valid = 1'b1; rd_addr = vecs[i].addr; rd_data = vecs[i].data;
            end
            #1;
            check_bit("vec_rd_ready", rd_ready, !vecs[i].src);
            check_bit("vec_wr_ready", wr_ready, vecs[i].src);
            exp_q.push_back(vecs[i].disp);
            @(posedge clk); #1;
            rd_valid = 1'b0; wr_valid = 1'b0;
            rd_addr = 8'($urandom); rd_data = 8'($urandom);
            wr_addr = 8'($urandom); wr_data = 8'($urandom);
            #1;
            pop_check("vec_disp");
            check_bit("vec_busy_first", busy, 1'b1);
            check_bit("vec_last_src", last_src, vecs[i].src);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #2;
                check_bit("vec_busy_hold", busy, 1'b1);
            end
            @(posedge clk); #2;
            check_bit("vec_busy_end", busy, 1'b0);
            check_disp("vec_disp_retained", disp, vecs[i].disp);
        end

        // Both sources pending from reset: rd, wr, rd, wr, five cycles apart.
        @(posedge clk); #1 rst = 1'b1;
        #1 check_disp("rst_blank", disp, Blank);
        @(posedge clk); #1 rst = 1'b0;
        rd_valid = 1'b1; rd_addr = 8'h11; rd_data = 8'h22;
        wr_valid = 1'b1; wr_addr = 8'h33; wr_data = 8'h44;
        for (int c = 0; c < 20; c++) begin
            #1;
            check_bit("rr_rd_ready", rd_ready, (c % 5 == 0) && ((c / 5) % 2 == 0));
            check_bit("rr_wr_ready", wr_ready, (c % 5 == 0) && ((c / 5) % 2 == 1));
            if (c % 5 == 0)
                exp_q.push_back(((c / 5) % 2 == 0) ? {5'd16, 5'd17, 5'd1, 5'd1, 5'd2, 5'd2}
                                                   : {5'd17, 5'd18, 5'd3, 5'd3, 5'd4, 5'd4});
            if (c % 5 == 1) begin
                pop_check("rr_disp");
                check_bit("rr_last_src", last_src, (c / 5) % 2 == 1);
            end
            @(posedge clk); #1;
        end
        rd_valid = 1'b0; wr_valid = 1'b0;
        wait_idle();

        // Write-only, back to back.
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_addr = 8'hFF; wr_data = 8'h00;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_bit("wr2_wr_ready", wr_ready, c % 5 == 0);
            check_bit("wr2_rd_ready", rd_ready, 1'b0);
            if (c % 5 == 0) exp_q.push_back({5'd17, 5'd18, 5'd15, 5'd15, 5'd0, 5'd0});
            if (c % 5 == 1) pop_check("wr2_disp");
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wait_idle();

        // clear on the 2nd hold cycle with a read still pending.
        @(posedge clk); #1;
        rd_valid = 1'b1; rd_addr = 8'h5A; rd_data = 8'hC3;
        #1 check_bit("clr_first_ready", rd_ready, 1'b1);
        exp_q.push_back({5'd16, 5'd17, 5'd5, 5'd10, 5'd12, 5'd3});
        @(posedge clk); #2;
        pop_check("clr_first_disp");
        @(posedge clk); #1 clear = 1'b1;
        #1;
        check_bit("clr_ready_low", rd_ready, 1'b0);
        check_bit("clr_busy_before", busy, 1'b1);
        @(posedge clk); #1 clear = 1'b0;
        #1;
        check_disp("clr_blank", disp, Blank);
        check_bit("clr_busy_after", busy, 1'b0);
        check_bit("clr_reaccept_ready", rd_ready, 1'b1);
        exp_q.push_back({5'd16, 5'd17, 5'd5, 5'd10, 5'd12, 5'd3});
        @(posedge clk); #1 rd_valid = 1'b0;
        #1;
        pop_check("clr_reaccept_disp");
        check_bit("clr_reaccept_busy", busy, 1'b1);
        wait_idle();

        // clear beats a valid in IDLE.
        @(posedge clk); #1;
        rd_valid = 1'b1; clear = 1'b1;
        #1;
        check_bit("idleclr_rd_ready", rd_ready, 1'b0);
        check_bit("idleclr_wr_ready", wr_ready, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0; rd_valid = 1'b0;
        #1;
        check_disp("idleclr_blank", disp, Blank);
        check_bit("idleclr_busy", busy, 1'b0);
        check_bit("idleclr_last_src", last_src, 1'b0);

        // One-cycle hold: accept every other cycle, then async reset mid-hold.
        @(posedge clk); #1 b_rd_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check_bit("h1_ready", b_rd_ready, c % 2 == 0);
            check_bit("h1_busy", b_busy, c % 2 == 1);
            if (c == 1) check_disp("h1_disp", b_disp, {5'd16, 5'd17, 5'd7, 5'd14, 5'd8, 5'd1});
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        #1 check_bit("h1_busy_pre_rst", b_busy, 1'b1);
        b_rst = 1'b1;
        #1;
        check_bit("arst_busy", b_busy, 1'b0);
        check_disp("arst_disp", b_disp, Blank);
        check_bit("arst_last_src", b_last_src, 1'b1);
        @(posedge clk); #1;
        b_rst = 1'b0; b_rd_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
